// File: rtl/comp_host_initiator_pkg.sv
// Shared widths, pin encodings and FSM states for the compression chip initiator.
package comp_pkg;

  localparam int DATA_W_DEF  = 80;
  localparam int CODE_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_COMP   = 2'b01,
    CMD_DECOMP = 2'b10,
    CMD_ERR    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    RSP_NONE      = 2'b00,
    RSP_COMP_OK   = 2'b01,
    RSP_DECOMP_OK = 2'b10,
    RSP_ERR       = 2'b11
  } rsp_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } state_e;

  // Only compress and decompress ever reach the chip.
  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == CMD_COMP) || (op == CMD_DECOMP);
  endfunction

endpackage

// File: rtl/comp_host_initiator_if.sv
// Host request/response handshakes plus the chip pin bundle driven by the initiator.
interface comp_host_initiator_if
  import comp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CODE_W = CODE_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_data;
  logic [CODE_W-1:0] req_code;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_status;
  logic              rsp_timeout;
  logic [CODE_W-1:0] rsp_code;
  logic [DATA_W-1:0] rsp_data;

  logic [1:0]        chip_command;
  logic [DATA_W-1:0] chip_data;
  logic [CODE_W-1:0] chip_code;
  logic [1:0]        chip_response;
  logic [CODE_W-1:0] chip_compressed;
  logic [DATA_W-1:0] chip_decompressed;

  modport master (
    input  req_valid, req_op, req_data, req_code, rsp_ready,
    input  chip_response, chip_compressed, chip_decompressed,
    output req_ready, rsp_valid, rsp_status, rsp_timeout, rsp_code, rsp_data,
    output chip_command, chip_data, chip_code
  );

  modport slave (
    output req_valid, req_op, req_data, req_code, rsp_ready,
    output chip_response, chip_compressed, chip_decompressed,
    input  req_ready, rsp_valid, rsp_status, rsp_timeout, rsp_code, rsp_data,
    input  chip_command, chip_data, chip_code
  );

endinterface

// File: rtl/comp_host_initiator_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module comp_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/comp_host_initiator.sv
// Host-side initiator for the compression chip: one-cycle command issue,
// bounded response wait, and a held result with a saturating error tally.
module comp_host_initiator
  import comp_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CODE_W  = CODE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  comp_host_initiator_if.master bus,
  output logic [CNT_W-1:0]      err_count
);

  // state | meaning
  // IDLE  | req_ready high, waiting for a request
  // ISSUE | chip_command carries the op for this single cycle
  // WAIT  | command back to NOP, sampling chip_response against the timer
  // HOLD  | rsp_valid high, result frozen until rsp_ready

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_WAIT  = ST_WAIT;
  localparam logic [1:0] S_HOLD  = ST_HOLD;

  logic [1:0]        state;
  logic [TMR_W-1:0]  timer_q;
  logic [1:0]        resp;
  logic [CODE_W-1:0] cmp_code;
  logic [DATA_W-1:0] dec_word;
  logic              acc;
  logic              tmo_hit;
  logic              timer_clr;
  logic              timer_inc;
  logic              err_inc;

  assign resp     = bus.chip_response;
  assign cmp_code = bus.chip_compressed;
  assign dec_word = bus.chip_decompressed;

  always_comb begin
    acc       = (state == S_IDLE) && bus.req_ready && bus.req_valid;
    // Last WAIT edge: the timer has counted TIMEOUT-1 silent cycles already.
    tmo_hit   = (timer_q == TMR_W'(TIMEOUT - 1));
    timer_clr = (state == S_ISSUE);
    timer_inc = (state == S_WAIT) && (resp == RSP_NONE);
    err_inc   = (acc && !op_is_valid(bus.req_op)) ||
                ((state == S_WAIT) &&
                 ((resp == RSP_ERR) || ((resp == RSP_NONE) && tmo_hit)));
  end

  comp_sat_counter #(.W(TMR_W)) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .inc   (timer_inc),
    .q     (timer_q)
  );

  comp_sat_counter #(.W(CNT_W)) u_err_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (err_inc),
    .q     (err_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      bus.req_ready    <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_status   <= RSP_NONE;
      bus.rsp_timeout  <= 1'b0;
      bus.rsp_code     <= '0;
      bus.rsp_data     <= '0;
      bus.chip_command <= CMD_NOP;
      bus.chip_data    <= '0;
      bus.chip_code    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (acc) begin
            bus.req_ready <= 1'b0;
            if (op_is_valid(bus.req_op)) begin
              bus.chip_command <= bus.req_op;
              bus.chip_data    <= bus.req_data;
              bus.chip_code    <= bus.req_code;
              state            <= S_ISSUE;
            end else begin
              bus.rsp_status  <= RSP_ERR;
              bus.rsp_timeout <= 1'b0;
              bus.rsp_valid   <= 1'b1;
              state           <= S_HOLD;
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end

        S_ISSUE: begin
          bus.chip_command <= CMD_NOP;
          state            <= S_WAIT;
        end

        S_WAIT: begin
          // A real response on the final cycle still beats the timeout.
          if (resp != RSP_NONE) begin
            bus.rsp_status <= resp;
            if (resp == RSP_COMP_OK) begin
              bus.rsp_code <= cmp_code;
            end
            if (resp == RSP_DECOMP_OK) begin
              bus.rsp_data <= dec_word;
            end
            bus.rsp_valid <= 1'b1;
            state         <= S_HOLD;
          end else if (tmo_hit) begin
            bus.rsp_status  <= RSP_ERR;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            state           <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.req_ready   <= 1'b1;
            state           <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
